// File: rtl/tone_nco.sv
// tone_nco
//
// Note-playing numerically controlled oscillator. A note command (start
// strobe with a frequency word and a duration) runs a phase accumulator.
// The note lasts for 'dur' pulses of the 'tick' time base. When it ends
// naturally, the block goes back to idle and pulses 'done'.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   note command strobe; samples freq and dur
//   stop   in   abort the current note without a done pulse
//   tick   in   duration time-base enable, one cycle wide
//   freq   in   phase increment per clk, zero-extended to ASZ
//   dur    in   note length in tick pulses
//   phs    out  top PSZ bits of the accumulator (registered)
//   busy   out  high while a note plays; this is the FSM state bit
//   done   out  one-cycle pulse on natural note completion
//
// Handshake: start/stop/tick are single-cycle strobes sampled on every
// rising edge, with no back-pressure. Per edge, the priority from highest to
// lowest is rst_n, stop, start, then tick/accumulate. busy reports whether
// a note is in progress. done marks the end of a note that completes
// naturally.
module tone_nco #(
  parameter int ASZ = 24,
  parameter int PSZ = 12,
  parameter int FSZ = 24,
  parameter int DSZ = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic           tick,
  input  logic [FSZ-1:0] freq,
  input  logic [DSZ-1:0] dur,
  output logic [PSZ-1:0] phs,
  output logic           busy,
  output logic           done
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_PLAY = 1'b1;

  logic           state_q, state_d;
  logic [ASZ-1:0] acc_q, acc_d;
  logic [FSZ-1:0] freq_q, freq_d;
  logic [DSZ-1:0] cnt_q, cnt_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        // stop outranks start, so a stop on the same edge suppresses the command.
        if (!stop && start) begin
          freq_d = freq;
          if (dur != '0) begin
            cnt_d   = dur;
            state_d = S_PLAY;
          end else begin
            // A zero-length note completes immediately.
            done_d = 1'b1;
          end
        end
      end
      default: begin
        // A retrigger keeps the old increment for this edge. This makes the
        // change of note phase-continuous.
        acc_d = acc_q + ASZ'(freq_q);
        if (stop) begin
          state_d = S_IDLE;
          acc_d   = '0;
        end else if (start) begin
          freq_d = freq;
          cnt_d  = dur;
          if (dur == '0) begin
            state_d = S_IDLE;
            acc_d   = '0;
            done_d  = 1'b1;
          end
        end else if (tick) begin
          cnt_d = cnt_q - DSZ'(1);
          if (cnt_q == DSZ'(1)) begin
            state_d = S_IDLE;
            acc_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      freq_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign phs  = acc_q[ASZ-1 -: PSZ];
  assign busy = (state_q == S_PLAY);
  assign done = done_q;

endmodule

// File: doc/tone_nco.md
# tone_nco

Note-playing numerically controlled oscillator for game sound effects. Accepts a note command (frequency word plus duration), runs a phase accumulator for that many duration ticks, then signals completion. Its `phs` output drives the phase input of the sine lookup stage directly. A small sequencer issues notes one at a time and watches `busy`/`done`.

## Interface

- `asz`, 24: accumulator width (bits)
- `psz`, 12: output phase width; must equal the sine stage's phase width; `psz` ≤ `asz`
- `fsz`, 24: frequency word width; `fsz` ≤ `asz`
- `dsz`, 16: duration counter width

- `clk`  in  1  main system clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle note command strobe; samples `freq` and `dur`
- `stop`  in  1  abort the current note; no `done` pulse
- `tick`  in  1  duration time-base enable, one cycle wide (e.g. 1 ms strobe)
- `freq`  in  `fsz`  phase increment per `clk`; zero-extended to `asz`
- `dur`  in  `dsz`  note length in `tick` pulses; unsigned
- `phs`  out  `psz`  phase word = `acc[asz-1:asz-psz]`; registered
- `busy`  out  1  high while a note plays (state PLAY)
- `done`  out  1  one-cycle pulse when a note completes naturally

## Operation

Registers:
- `acc` [`asz`]
- `freq_r` [`fsz`]
- `cnt` [`dsz`]
- `state` ∈ {IDLE, PLAY}
- `done`

Priority per edge, highest first: `rst_n`=0 > `stop` > `start` > `tick`/accumulate.

Reset (`rst_n`=0 at an edge):
- state=IDLE, `acc`=0, `freq_r`=0, `cnt`=0
- `phs`=0, `busy`=0, `done`=0
- Reset mid-note abandons the note silently.

IDLE:
- `acc` holds 0.
- `start` with `dur`≠0:
  - latch `freq_r`←`freq`, `cnt`←`dur`, `acc`←0
  - go to PLAY
- `start` with `dur`=0:
  - stay IDLE
  - `done`=1 on the next cycle (zero-length note)
  - `freq_r` is still latched
- `stop` in IDLE: no effect.
- `tick` in IDLE: ignored.

PLAY:
- Accumulate every cycle: `acc`←`acc`+`freq_r`, modulo 2^`asz`. Wrap is silent.
- On `tick`:
  - `cnt`←`cnt`−1
  - if `cnt`=1 at that edge: go to IDLE, `acc`←0, pulse `done`
- `start` in PLAY (retrigger):
  - `freq_r`←`freq`, `cnt`←`dur`
  - `acc` continues (`acc`←`acc`+`freq_r`(old)), giving a phase-continuous note change
  - that edge's `tick` is ignored
  - retrigger with `dur`=0: go to IDLE with `done` pulse, `acc`←0
- `start` coinciding with the final `tick`: `start` wins, no `done`.
- `stop` in PLAY: go to IDLE, `acc`←0, `done` stays 0. `stop`+`start` on the same edge: `stop` wins.

Other rules:
- `freq`=0 is legal: `phs` stays at 0 for the whole duration, and `busy`/`done` behave normally.
- `done` is high for exactly one cycle. It is never asserted in the same cycle as a new PLAY entry.

## Timing

- `start` sampled at edge N (IDLE):
  - after N: `busy`=1, `phs`=0
  - after N+1: `acc`=`freq`
  - after N+k: `acc`=k·`freq` mod 2^`asz`
- `phs` is a direct register slice. There is no extra pipeline stage; the sine stage adds its own latency downstream.
- Final `tick` at edge M:
  - after M: `busy`=0, `done`=1, `phs`=0
  - after M+1: `done`=0
- A note of `dur`=D ends on the D-th `tick` observed after the `start` edge. A `tick` coincident with the `start` edge does not count.
- `stop` at edge S: after S, `busy`=0 and `phs`=0.
- Back-to-back: `start` on the cycle `done` is high is accepted normally.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `start`=1 and `tick`=1. → `phs`=0, `busy`=0, `done`=0 throughout. First edge after release with `start`=0: outputs stay 0.
- **Basic note** (`asz`=24, `psz`=12): `freq`=0x100000, `dur`=3, `start` at edge 0, `tick` at edges 5, 9, 13.
  - `phs` sequence after edges 0..4: 0x000, 0x100, 0x200, 0x300, 0x400
  - `phs` wraps 0xF00→0x000 at edge 16 only if the note is still running; it is not, because the note ends at edge 13
  - after edge 13: `busy`=0, `done`=1 for one cycle, `phs`=0
- **Wrap-around:** `freq`=0xF00000, `dur`=100. → `phs` after edges 1, 2, 3: 0xF00, 0xE00, 0xD00 (modulo wrap, no saturation).
- **Zero duration:** `start` with `dur`=0 in IDLE. → `busy` stays 0; `done`=1 exactly one cycle after the `start` edge.
- **Retrigger:** in PLAY with `acc`=0x300000, apply `start` with `freq`=0x200000, `dur`=2, plus a simultaneous final `tick`.
  - no `done`; `busy` stays 1
  - `phs` after that edge: 0x400 (old increment), then 0x600, 0x800
  - `done` on the 2nd following `tick`
- **Abort:** `stop` asserted mid-note together with `start`. → after that edge: `busy`=0, `phs`=0; `done` stays 0 for the next 4 cycles.
